systolic_feeder: RTL and testbench



---
 rtl/systolic_pkg.sv | 28 ++
 rtl/skew_delay.sv | 49 ++++
 rtl/systolic_feeder.sv | 120 ++++++++++++
 tb/tb_systolic_feeder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared types for the systolic array edge feeders: the nibble
//                type, the per-lane token carried through the skew chains and
//                the serialiser state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // One slot of a lane: valid tag, start-of-operand tag and the nibble.
    typedef struct packed {
        logic    valid;
        logic    ctrl;
        nibble_t data;
    } lane_tok_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } feeder_state_t;

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/skew_delay.sv
`default_nettype none
// ============================================================================
//  Module      : skew_delay
//  Description : DEPTH-stage shift register of lane tokens with clock enable
//                and synchronous active-low flush. DEPTH=1 acts as a plain
//                output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_delay
    import systolic_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ena,
    input  lane_tok_t tok_in,
    output lane_tok_t tok_out,
    output logic      any_valid
);

    lane_tok_t r_stage [DEPTH];

    // Shift tokens one stage per enabled cycle; reset flushes every stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_stage[s] <= '0;
            end
        end else if (ena) begin
            r_stage[0] <= tok_in;
            for (int s = 1; s < DEPTH; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    // Any stage still carrying a valid nibble keeps the feeder busy.
    always_comb begin
        any_valid = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            any_valid = any_valid | r_stage[s].valid;
        end
    end

    assign tok_out = r_stage[DEPTH-1];

endmodule : skew_delay
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_feeder
//  Description : Accepts one operand per lane over valid/ready, serialises it
//                low nibble first and skews lane i by i*SKEW cycles so the
//                operands enter the systolic array on the diagonal.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DW    = 8,
    parameter int NW    = 4,
    parameter int SKEW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_data,
    output logic [LANES*NW-1:0] lane_data,
    output logic [LANES-1:0]    lane_ctrl,
    output logic                busy
);

    localparam int c_NIB   = DW / NW;
    localparam int c_IDX_W = (c_NIB > 1) ? $clog2(c_NIB) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NIB - 1);

    feeder_state_t       r_state;
    feeder_state_t       w_state_nxt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_IDX_W-1:0]  w_idx_nxt;
    logic [LANES*DW-1:0] r_word;
    logic                w_accept;
    logic [LANES-1:0]    w_lane_valid;

    // Ready while idle or on the last nibble, so back-to-back words are gapless.
    assign in_ready = rst_n & ena &
                      ((r_state == IDLE) | ((r_state == EMIT) & (r_idx == c_LAST)));
    assign w_accept = in_valid & in_ready;

    // Serialiser state register; everything freezes while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state: accept restarts at nibble 0, otherwise step or return to idle.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_accept) begin
            w_state_nxt = EMIT;
            w_idx_nxt   = '0;
        end else if (r_state == EMIT) begin
            if (r_idx == c_LAST) begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end else begin
                w_idx_nxt = r_idx + 1'b1;
            end
        end
    end

    // Hold the operand word; in_data only matters at the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word <= '0;
        end else if (w_accept) begin
            r_word <= in_data;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            lane_tok_t w_tok_in;
            lane_tok_t w_tok_out;

            // Pre-skew token: current nibble of this lane, zero when idle.
            always_comb begin
                w_tok_in = '0;
                if (r_state == EMIT) begin
                    w_tok_in.valid = 1'b1;
                    w_tok_in.ctrl  = (r_idx == '0);
                    for (int n = 0; n < c_NIB; n++) begin
                        if (r_idx == c_IDX_W'(n)) begin
                            w_tok_in.data = r_word[gi*DW + n*NW +: NW];
                        end
                    end
                end
            end

            skew_delay #(
                .DEPTH (1 + gi*SKEW)
            ) u_skew (
                .clk       (clk),
                .rst_n     (rst_n),
                .ena       (ena),
                .tok_in    (w_tok_in),
                .tok_out   (w_tok_out),
                .any_valid (w_lane_valid[gi])
            );

            assign lane_data[gi*NW +: NW] = w_tok_out.valid ? w_tok_out.data : '0;
            assign lane_ctrl[gi]          = w_tok_out.valid & w_tok_out.ctrl;
        end
    endgenerate

    assign busy = (r_state == EMIT) | (|w_lane_valid);

endmodule : systolic_feeder
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_feeder
//  Description : Scoreboard bench for systolic_feeder. Accepted words are
//                expanded into per-lane expected nibbles tagged with the
//                enabled-cycle count at which they must appear; a monitor
//                compares the lane outputs, busy and in_ready every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

    localparam int LANES = 2;
    localparam int DW    = 8;
    localparam int NW    = 4;
    localparam int SKEW  = 2;
    localparam int NIB   = DW / NW;

    typedef struct {
        int         due;
        logic [3:0] d;
        logic       c;
    } item_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ena = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [LANES*DW-1:0] in_data = '0;
    logic [LANES*NW-1:0] lane_data;
    logic [LANES-1:0]    lane_ctrl;
    logic                busy;

    int    compared   = 0;
    int    mismatched = 0;
    int    ecount     = 0;
    int    last_acc   = 0;
    int    acc_cnt    = 0;
    bit    have_word  = 1'b0;
    bit    mon_en     = 1'b0;
    item_t exp_q [LANES][$];

    systolic_feeder #(
        .LANES (LANES),
        .DW    (DW),
        .NW    (NW),
        .SKEW  (SKEW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .lane_data (lane_data),
        .lane_ctrl (lane_ctrl),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // A new word is accepted when idle or when the previous one is on its last nibble.
    function automatic bit model_ready();
        return rst_n && ena && (!have_word || (ecount >= last_acc + NIB - 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: on each accept, schedule every nibble of every lane.
    always @(posedge clk) begin
        bit rdy;
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) exp_q[i].delete();
            have_word = 1'b0;
            ecount    = 0;
        end else if (ena) begin
            rdy = model_ready();
            ecount++;
            if (in_valid && rdy) begin
                last_acc  = ecount;
                have_word = 1'b1;
                acc_cnt++;
                for (int i = 0; i < LANES; i++) begin
                    for (int n = 0; n < NIB; n++) begin
                        item_t it;
                        it.due = ecount + 1 + i*SKEW + n;
                        it.d   = in_data[i*DW + n*NW +: NW];
                        it.c   = (n == 0);
                        exp_q[i].push_back(it);
                    end
                end
            end
        end
    end

    // Monitor: compare outputs against the scheduled nibbles at the current count.
    always @(negedge clk) begin
        logic [3:0] ed;
        logic       ec;
        bit         busy_exp;
        if (mon_en) begin
            busy_exp = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                while (exp_q[i].size() > 0 && exp_q[i][0].due < ecount) void'(exp_q[i].pop_front());
                ed = 4'h0;
                ec = 1'b0;
                if (exp_q[i].size() > 0) begin
                    busy_exp = 1'b1;
                    if (exp_q[i][0].due == ecount) begin
                        ed = exp_q[i][0].d;
                        ec = exp_q[i][0].c;
                    end
                end
                chk($sformatf("lane%0d_data", i), 32'(lane_data[i*NW +: NW]), 32'(ed));
                chk($sformatf("lane%0d_ctrl", i), 32'(lane_ctrl[i]), 32'(ec));
            end
            chk("busy", 32'(busy), 32'(busy_exp));
            chk("in_ready", 32'(in_ready), 32'(model_ready()));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [LANES*DW-1:0] w);
        int start;
        start    = acc_cnt;
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 50 && acc_cnt == start; n++) @(negedge clk);
        if (acc_cnt == start) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got no accept expected accept of %0h", w);
        end
        #1;
    endtask

    initial begin
        // Reset and idle
        rst_n = 1'b0;
        ena   = 1'b1;
        @(negedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step();

        // Single word
        send(16'h3CA5);
        in_valid = 1'b0;
        repeat (6) step();

        // Back-to-back
        send(16'h5612);
        send(16'h7834);
        in_valid = 1'b0;
        repeat (8) step();

        // Stall right after lane 0 shows its first nibble
        send(16'h3CA5);
        in_valid = 1'b0;
        step();
        ena = 1'b0;
        repeat (3) step();
        ena = 1'b1;
        repeat (8) step();

        // Reset mid-flight
        send(16'hEEFF);
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (8) step();

        // in_data changes while not ready are ignored
        send(16'h3CA5);
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
        step();
        in_data  = 16'h0000;
        repeat (8) step();

        // Randomised traffic with enable stalls and occasional resets
        for (int t = 0; t < 600; t++) begin
            ena      = ($urandom % 5) != 0;
            in_valid = ($urandom % 3) != 0;
            in_data  = LANES*DW'($urandom);
            rst_n    = ($urandom % 150) != 0;
            step();
        end

        rst_n    = 1'b1;
        ena      = 1'b1;
        in_valid = 1'b0;
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_systolic_feeder
`default_nettype wire
